// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Optional forwarding is selected with the HAZ_FWD_EN macro.
package pipe_ctrl_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        MUL_BUSY = 1'b1
    } state_t;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_MEMWB = 2'b01;

    localparam int REG_W_DEF = 5;
    // Wide enough for the largest legal multiplier latency (15).
    localparam int CNT_W     = 4;

endpackage

// File: rtl/pipe_fwd_unit.sv
// Source/destination comparators for the ID-stage operands; drives fwd_a/fwd_b only when HAZ_FWD_EN is defined.
// Purely combinational, zero latency, no backpressure.
module pipe_fwd_unit
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_W = REG_W_DEF
) (
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic [REG_W-1:0] ex_rd,
    input  logic [REG_W-1:0] mem_rd,
    input  logic             mem_reg_write,
    input  logic [REG_W-1:0] wb_rd,
    input  logic             wb_reg_write,
    output logic             ex_src_hit,
    output logic             mem_src_hit,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b
);

    logic rs_ex, rt_ex, rs_mem, rt_mem;

    // r0 is hard-wired, so a zero destination never creates a dependency.
    assign rs_ex  = id_uses_rs && (id_rs != '0) && (id_rs == ex_rd);
    assign rt_ex  = id_uses_rt && (id_rt != '0) && (id_rt == ex_rd);
    assign rs_mem = id_uses_rs && (id_rs != '0) && (id_rs == mem_rd) && mem_reg_write;
    assign rt_mem = id_uses_rt && (id_rt != '0) && (id_rt == mem_rd) && mem_reg_write;

    assign ex_src_hit  = rs_ex  || rt_ex;
    assign mem_src_hit = rs_mem || rt_mem;

`ifdef HAZ_FWD_EN
    logic rs_wb, rt_wb;

    assign rs_wb = id_uses_rs && (id_rs != '0) && (id_rs == wb_rd) && wb_reg_write;
    assign rt_wb = id_uses_rt && (id_rt != '0) && (id_rt == wb_rd) && wb_reg_write;

    // The younger producer (EX/MEM) holds the newer value and wins.
    assign fwd_a = rs_mem ? FWD_EXMEM : (rs_wb ? FWD_MEMWB : FWD_RF);
    assign fwd_b = rt_mem ? FWD_EXMEM : (rt_wb ? FWD_MEMWB : FWD_RF);
`else
    logic unused_wb;

    assign unused_wb = ^{wb_rd, wb_reg_write};
    assign fwd_a     = FWD_RF;
    assign fwd_b     = FWD_RF;
`endif

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline register enable/flush sequencing: branch squash, multiplier stall, load-use/RAW stall.
// Hazard outputs are combinational; mult_busy/hilo_write_en registered. HAZ_FWD_EN enables forwarding.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MULT_LAT = 4,
    parameter int REG_W    = REG_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_reg_write,
    input  logic             ex_mem_read,
    input  logic             ex_is_mult,
    input  logic [REG_W-1:0] mem_rd,
    input  logic [REG_W-1:0] wb_rd,
    input  logic             mem_reg_write,
    input  logic             wb_reg_write,
    input  logic             mem_branch_taken,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             idex_write,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             mult_busy,
    output logic             hilo_write_en
);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             hilo_nxt;
    logic             ex_src_hit, mem_src_hit, stall;
    logic [1:0]       fwd_a_u, fwd_b_u;

    pipe_fwd_unit #(.REG_W(REG_W)) u_fwd (
        .id_rs         (id_rs),
        .id_rt         (id_rt),
        .id_uses_rs    (id_uses_rs),
        .id_uses_rt    (id_uses_rt),
        .ex_rd         (ex_rd),
        .mem_rd        (mem_rd),
        .mem_reg_write (mem_reg_write),
        .wb_rd         (wb_rd),
        .wb_reg_write  (wb_reg_write),
        .ex_src_hit    (ex_src_hit),
        .mem_src_hit   (mem_src_hit),
        .fwd_a         (fwd_a_u),
        .fwd_b         (fwd_b_u)
    );

`ifdef HAZ_FWD_EN
    logic unused_raw;

    assign unused_raw = ^{ex_reg_write, mem_src_hit};
    assign stall      = ex_mem_read && ex_src_hit;
`else
    // Without bypass paths the consumer waits until the producer reaches WB.
    assign stall = (ex_src_hit && (ex_mem_read || ex_reg_write)) || mem_src_hit;
`endif

    assign fwd_a     = rst_n ? fwd_a_u : FWD_RF;
    assign fwd_b     = rst_n ? fwd_b_u : FWD_RF;
    assign mult_busy = (state == MUL_BUSY);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= RUN;
            cnt           <= '0;
            hilo_write_en <= 1'b0;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            hilo_write_en <= hilo_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        hilo_nxt  = 1'b0;
        case (state)
            RUN: begin
                // The completing multiply still sits in EX during its HiLo strobe; do not restart it.
                if (ex_is_mult && !mem_branch_taken && !hilo_write_en) begin
                    state_nxt = MUL_BUSY;
                    cnt_nxt   = CNT_W'(MULT_LAT - 1);
                end
            end
            MUL_BUSY: begin
                if (mem_branch_taken) begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_W'(1)) begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                    hilo_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            default: begin
                state_nxt = RUN;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        idex_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        if (!rst_n) begin
            pc_write = 1'b1;
        end else if (mem_branch_taken) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
        end else if (state == MUL_BUSY) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_write  = 1'b0;
            exmem_flush = 1'b1;
        end else if (stall) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl; expectations follow the HAZ_FWD_EN setting of the build.
module tb_pipe_hazard_ctrl;

    localparam int ML = 4;
    localparam logic [5:0] C_RUN   = 6'b111000;
    localparam logic [5:0] C_STALL = 6'b001010;
    localparam logic [5:0] C_MUL   = 6'b000001;
    localparam logic [5:0] C_BR    = 6'b111111;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] id_rs, id_rt, ex_rd, mem_rd, wb_rd;
    logic       id_uses_rs, id_uses_rt, ex_reg_write, ex_mem_read, ex_is_mult;
    logic       mem_reg_write, wb_reg_write, mem_branch_taken;
    logic       pc_write, ifid_write, idex_write, ifid_flush, idex_flush, exmem_flush;
    logic [1:0] fwd_a, fwd_b;
    logic       mult_busy, hilo_write_en;
    logic [5:0] ctrl;
    int         n_chk = 0;
    int         n_pass = 0;
    logic       seen;

    assign ctrl = {pc_write, ifid_write, idex_write, ifid_flush, idex_flush, exmem_flush};

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.MULT_LAT(ML), .REG_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_is_mult(ex_is_mult),
        .mem_rd(mem_rd), .wb_rd(wb_rd), .mem_reg_write(mem_reg_write), .wb_reg_write(wb_reg_write),
        .mem_branch_taken(mem_branch_taken),
        .pc_write(pc_write), .ifid_write(ifid_write), .idex_write(idex_write),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .mult_busy(mult_busy), .hilo_write_en(hilo_write_en)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    task automatic clr_in();
        id_rs = '0; id_rt = '0; id_uses_rs = 0; id_uses_rt = 0;
        ex_rd = '0; ex_reg_write = 0; ex_mem_read = 0; ex_is_mult = 0;
        mem_rd = '0; wb_rd = '0; mem_reg_write = 0; wb_reg_write = 0;
        mem_branch_taken = 0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        clr_in();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        check("reset_ctrl", {2'b0, ctrl}, {2'b0, C_RUN});
        check("reset_fwd", {4'b0, fwd_a, fwd_b}, 8'h00);
        check("reset_mul", {6'b0, mult_busy, hilo_write_en}, 8'h00);
        #9 rst_n = 1'b1;
        cyc();

        // T1: load r2 in EX, ID reads r2
        ex_rd = 5'd2; ex_mem_read = 1; ex_reg_write = 1; id_rs = 5'd2; id_uses_rs = 1;
        #1 check("t1_loaduse", {2'b0, ctrl}, {2'b0, C_STALL});
        id_uses_rs = 0;
        #1 check("t1_unused_src", {2'b0, ctrl}, {2'b0, C_RUN});
        id_uses_rs = 1;
        cyc();
        ex_rd = '0; ex_mem_read = 0; ex_reg_write = 0; mem_rd = 5'd2; mem_reg_write = 1;
        #1;
`ifdef HAZ_FWD_EN
        check("t1_release", {2'b0, ctrl}, {2'b0, C_RUN});
        check("t1_fwd_a", {6'b0, fwd_a}, 8'h02);
`else
        check("t1_raw_mem", {2'b0, ctrl}, {2'b0, C_STALL});
`endif
        clr_in();
        ex_rd = 5'd7; ex_mem_read = 1; ex_reg_write = 1; id_rt = 5'd7; id_uses_rt = 1;
        #1 check("t1_loaduse_rt", {2'b0, ctrl}, {2'b0, C_STALL});
        clr_in();
        ex_mem_read = 1; ex_reg_write = 1; id_uses_rs = 1;
        #1 check("t1_r0_nohaz", {2'b0, ctrl}, {2'b0, C_RUN});
        cyc();

        // T2: forwarding selection
        clr_in();
        mem_rd = 5'd3; mem_reg_write = 1; wb_rd = 5'd3; wb_reg_write = 1; id_rs = 5'd3; id_uses_rs = 1;
        #1;
`ifdef HAZ_FWD_EN
        check("t2_fwd_exmem", {6'b0, fwd_a}, 8'h02);
        check("t2_no_stall", {2'b0, ctrl}, {2'b0, C_RUN});
`else
        check("t2_fwd_tied", {4'b0, fwd_a, fwd_b}, 8'h00);
        check("t2_raw_stall", {2'b0, ctrl}, {2'b0, C_STALL});
`endif
        mem_reg_write = 0;
        #1;
`ifdef HAZ_FWD_EN
        check("t2_fwd_memwb", {6'b0, fwd_a}, 8'h01);
`else
        check("t2_fwd_tied2", {6'b0, fwd_a}, 8'h00);
`endif
        check("t2_wb_nostall", {2'b0, ctrl}, {2'b0, C_RUN});
        mem_rd = '0; wb_rd = '0; id_rs = '0; mem_reg_write = 1;
        #1 check("t2_fwd_r0", {6'b0, fwd_a}, 8'h00);
        clr_in();
        id_rt = 5'd4; id_uses_rt = 1; wb_rd = 5'd4; wb_reg_write = 1;
        #1;
`ifdef HAZ_FWD_EN
        check("t2_fwd_b", {4'b0, fwd_a, fwd_b}, 8'h01);
`else
        check("t2_fwd_b_tied", {4'b0, fwd_a, fwd_b}, 8'h00);
`endif
        cyc();

        // T5: ALU producer r5 walks EX -> MEM -> WB
        clr_in();
        ex_rd = 5'd5; ex_reg_write = 1; id_rs = 5'd5; id_uses_rs = 1;
        #1;
`ifdef HAZ_FWD_EN
        check("t5_ex", {2'b0, ctrl}, {2'b0, C_RUN});
`else
        check("t5_ex", {2'b0, ctrl}, {2'b0, C_STALL});
`endif
        cyc();
        ex_rd = '0; ex_reg_write = 0; mem_rd = 5'd5; mem_reg_write = 1;
        #1;
`ifdef HAZ_FWD_EN
        check("t5_mem", {2'b0, ctrl}, {2'b0, C_RUN});
`else
        check("t5_mem", {2'b0, ctrl}, {2'b0, C_STALL});
`endif
        cyc();
        mem_rd = '0; mem_reg_write = 0; wb_rd = 5'd5; wb_reg_write = 1;
        #1 check("t5_wb_release", {2'b0, ctrl}, {2'b0, C_RUN});
        cyc();

        // T3: full multiply, MULT_LAT = 4
        clr_in();
        ex_is_mult = 1;
        #1 check("t3_enter", {mult_busy, hilo_write_en, ctrl}, {2'b00, C_RUN});
        for (int i = 0; i < ML - 1; i++) begin
            cyc();
            check($sformatf("t3_busy%0d", i), {mult_busy, hilo_write_en, ctrl}, {2'b10, C_MUL});
        end
        cyc();
        check("t3_hilo", {mult_busy, hilo_write_en, ctrl}, {2'b01, C_RUN});
        ex_is_mult = 0;
        cyc();
        check("t3_after", {mult_busy, hilo_write_en, ctrl}, {2'b00, C_RUN});

        // T4: branch taken in the second busy cycle
        ex_is_mult = 1;
        cyc();
        cyc();
        mem_branch_taken = 1;
        #1 check("t4_branch", {mult_busy, hilo_write_en, ctrl}, {2'b10, C_BR});
        cyc();
        clr_in();
        #1 check("t4_run", {mult_busy, hilo_write_en, ctrl}, {2'b00, C_RUN});
        seen = 0;
        for (int i = 0; i < ML + 1; i++) begin
            cyc();
            seen = seen | hilo_write_en | mult_busy;
        end
        check("t4_no_hilo", {7'b0, seen}, 8'h00);

        // T6: asynchronous reset mid-multiply
        ex_is_mult = 1;
        cyc();
        cyc();
        check("t6_busy", {7'b0, mult_busy}, 8'h01);
        mem_rd = 5'd3; mem_reg_write = 1; id_rs = 5'd3; id_uses_rs = 1;
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_ctrl", {mult_busy, hilo_write_en, ctrl}, {2'b00, C_RUN});
        check("t6_rst_fwd", {4'b0, fwd_a, fwd_b}, 8'h00);
        clr_in();
        #4 rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < ML + 2; i++) begin
            cyc();
            seen = seen | hilo_write_en | mult_busy;
        end
        check("t6_no_hilo", {7'b0, seen}, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
